pll_phase_ctrl: RTL and testbench

Sequencer that drives the dynamic phase-adjust port of the SerDes PLL (25 MHz in; 250 MHz CLKOP/CLKOS; 125 MHz CLKOS2/CLKOS3).
- Accepts a valid/ready request for N phase steps on one PLL output.
- Generates correctly spaced PHASESEL/PHASEDIR/PHASESTEP/PHASELOADREG waveforms and waits for the PLL to report LOCK.
- Sits directly upstream of the PLL instance and is clocked by the PLL reference clock.

---
 rtl/pll_phase_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_pll_phase_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_phase_ctrl.sv
// Dynamic phase-adjust sequencer for the SerDes PLL: steps one output N times, optionally loads, then waits for LOCK.
// Optional per-output position tracking is built when PLL_PHASE_POS_TRACK_EN is defined.
module pll_phase_ctrl #(
    parameter int unsigned SETUP_CYC    = 2,
    parameter int unsigned PULSE_CYC    = 2,
    parameter int unsigned GAP_CYC      = 4,
    parameter int unsigned STEP_W       = 8,
    parameter int unsigned LOCK_TIMEOUT = 1024,
    parameter int unsigned POS_W        = 10
) (
    input  logic              CLKI,
    input  logic              RST,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic [1:0]        REQ_SEL,
    input  logic              REQ_DIR,
    input  logic [STEP_W-1:0] REQ_STEPS,
    input  logic              REQ_LOAD,
    input  logic              PLL_LOCK,
    output logic [1:0]        PHASESEL,
    output logic              PHASEDIR,
    output logic              PHASESTEP,
    output logic              PHASELOADREG,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    input  logic [1:0]        POS_RD_SEL,
    output logic [POS_W-1:0]  POS
);

    localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT + SETUP_CYC + PULSE_CYC + GAP_CYC + 1);

    typedef enum logic [2:0] {
        IDLE, SETUP, PULSE, GAP, LOAD, WAIT_LOCK, DONE_ST
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [STEP_W-1:0]   rem_q, rem_d;
    logic                load_q, load_d;
    logic [1:0]          phasesel_q, phasesel_d;
    logic                phasedir_q, phasedir_d;
    logic                err_q, err_d;
    logic                phasestep_q, phasestep_d;
    logic                phaseloadreg_q, phaseloadreg_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                req_ready_q, req_ready_d;
    logic                lock_meta_q, lock_s_q;

    // Next-state and registered-output computation; cnt counts cycles spent in the current state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        rem_d      = rem_q;
        load_d     = load_q;
        phasesel_d = phasesel_q;
        phasedir_d = phasedir_q;
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (REQ_VALID) begin
                    phasesel_d = REQ_SEL;
                    phasedir_d = REQ_DIR;
                    rem_d      = REQ_STEPS;
                    load_d     = REQ_LOAD;
                    err_d      = 1'b0;
                    if (REQ_STEPS != '0)  state_d = SETUP;
                    else if (REQ_LOAD)    state_d = LOAD;
                    else                  state_d = WAIT_LOCK;
                end
            end
            SETUP: begin
                if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
                    state_d = PULSE;
                    cnt_d   = '0;
                end
            end
            PULSE: begin
                if (cnt_q == CNT_W'(PULSE_CYC - 1)) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                    cnt_d = '0;
                    rem_d = rem_q - STEP_W'(1);
                    if (rem_q != STEP_W'(1)) state_d = PULSE;
                    else if (load_q)         state_d = LOAD;
                    else                     state_d = WAIT_LOCK;
                end
            end
            LOAD: begin
                // PULSE_CYC high cycles followed by one low cycle before waiting for lock
                if (cnt_q == CNT_W'(PULSE_CYC)) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            WAIT_LOCK: begin
                if (lock_s_q) begin
                    state_d = DONE_ST;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    state_d = DONE_ST;
                    err_d   = 1'b1;
                end
            end
            DONE_ST: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        phasestep_d    = (state_d == PULSE);
        phaseloadreg_d = (state_d == LOAD) && (cnt_d < CNT_W'(PULSE_CYC));
        busy_d         = (state_d != IDLE);
        done_d         = (state_d == DONE_ST);
        req_ready_d    = (state_d == IDLE);
    end

    always_ff @(posedge CLKI or posedge RST) begin
        if (RST) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            rem_q          <= '0;
            load_q         <= 1'b0;
            phasesel_q     <= 2'd0;
            phasedir_q     <= 1'b0;
            err_q          <= 1'b0;
            phasestep_q    <= 1'b0;
            phaseloadreg_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            req_ready_q    <= 1'b1;
            lock_meta_q    <= 1'b0;
            lock_s_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            rem_q          <= rem_d;
            load_q         <= load_d;
            phasesel_q     <= phasesel_d;
            phasedir_q     <= phasedir_d;
            err_q          <= err_d;
            phasestep_q    <= phasestep_d;
            phaseloadreg_q <= phaseloadreg_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            req_ready_q    <= req_ready_d;
            lock_meta_q    <= PLL_LOCK;
            lock_s_q       <= lock_meta_q;
        end
    end

    assign REQ_READY    = req_ready_q;
    assign PHASESEL     = phasesel_q;
    assign PHASEDIR     = phasedir_q;
    assign PHASESTEP    = phasestep_q;
    assign PHASELOADREG = phaseloadreg_q;
    assign BUSY         = busy_q;
    assign DONE         = done_q;
    assign ERR          = err_q;

`ifdef PLL_PHASE_POS_TRACK_EN
    logic [POS_W-1:0] pos_q [4];
    logic [POS_W-1:0] pos_d [4];

    // Count once per PHASESTEP rising edge, i.e. on each entry into PULSE.
    always_comb begin
        for (int i = 0; i < 4; i++) pos_d[i] = pos_q[i];
        if ((state_q != PULSE) && (state_d == PULSE)) begin
            pos_d[phasesel_q] = phasedir_q ? pos_q[phasesel_q] - POS_W'(1)
                                           : pos_q[phasesel_q] + POS_W'(1);
        end
    end

    always_ff @(posedge CLKI or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 4; i++) pos_q[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) pos_q[i] <= pos_d[i];
        end
    end

    assign POS = pos_q[POS_RD_SEL];
`else
    logic unused_pos_rd_sel;
    assign unused_pos_rd_sel = ^POS_RD_SEL;
    assign POS               = '0;
`endif

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Self-checking bench for pll_phase_ctrl: randomized requests against a timing-formula reference model.
module tb_pll_phase_ctrl;

    localparam int S      = 2;
    localparam int P      = 2;
    localparam int G      = 4;
    localparam int STEP_W = 8;
    localparam int TO     = 16;
    localparam int POS_W  = 10;
`ifdef PLL_PHASE_POS_TRACK_EN
    localparam bit POS_EN = 1'b1;
`else
    localparam bit POS_EN = 1'b0;
`endif

    logic              CLKI, RST, REQ_VALID, REQ_READY, REQ_DIR, REQ_LOAD, PLL_LOCK;
    logic [1:0]        REQ_SEL, PHASESEL, POS_RD_SEL;
    logic [STEP_W-1:0] REQ_STEPS;
    logic              PHASEDIR, PHASESTEP, PHASELOADREG, BUSY, DONE, ERR;
    logic [POS_W-1:0]  POS;

    int n_checks = 0;
    int n_fail   = 0;
    int pos_m [4];

    pll_phase_ctrl #(
        .SETUP_CYC(S), .PULSE_CYC(P), .GAP_CYC(G),
        .STEP_W(STEP_W), .LOCK_TIMEOUT(TO), .POS_W(POS_W)
    ) dut (
        .CLKI(CLKI), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_SEL(REQ_SEL), .REQ_DIR(REQ_DIR), .REQ_STEPS(REQ_STEPS), .REQ_LOAD(REQ_LOAD),
        .PLL_LOCK(PLL_LOCK), .PHASESEL(PHASESEL), .PHASEDIR(PHASEDIR), .PHASESTEP(PHASESTEP),
        .PHASELOADREG(PHASELOADREG), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
        .POS_RD_SEL(POS_RD_SEL), .POS(POS)
    );

    initial CLKI = 1'b0;
    always #5 CLKI = ~CLKI;

    task automatic tick();
        @(posedge CLKI);
        #1;
    endtask

    // Step k is high over [1+S+k(P+G), S+k(P+G)+P] counted from the acceptance edge.
    function automatic logic exp_step(input int c, input int steps);
        for (int k = 0; k < steps; k++)
            if (c >= 1 + S + k * (P + G) && c <= S + k * (P + G) + P) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_move(input int sel, input logic dir, input int steps);
        pos_m[sel] = (pos_m[sel] + (dir ? -steps : steps)) & ((1 << POS_W) - 1);
    endfunction

    task automatic check_pos_all();
        logic [POS_W-1:0] want;
        for (int r = 0; r < 4; r++) begin
            POS_RD_SEL = 2'(r);
            #1;
            want = POS_EN ? POS_W'(pos_m[r]) : '0;
            n_checks++;
            if (POS !== want) begin
                n_fail++;
                $display("FAIL pos[%0d]: got %h want %h", r, POS, want);
            end
        end
    endtask

    task automatic wait_ready();
        int i;
        for (i = 0; i < 200 && REQ_READY !== 1'b1; i++) tick();
        if (i == 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_ready: REQ_READY=%b want 1 within 200 cycles", REQ_READY);
        end
    endtask

    task automatic run_req(input logic [1:0] sel, input logic dir, input int steps,
                           input logic load, input bit glitch);
        int t_load, t_wait, t_done;
        logic [8:0] got, want;
        wait_ready();
        REQ_SEL = sel; REQ_DIR = dir; REQ_STEPS = STEP_W'(steps); REQ_LOAD = load;
        REQ_VALID = 1'b1;
        tick();
        REQ_VALID = 1'b0;
        t_load = (steps > 0) ? 1 + S + steps * (P + G) : 1;
        t_wait = t_load + (load ? P + 1 : 0);
        t_done = t_wait + 1;
        for (int c = 1; c <= t_done + 1; c++) begin
            want = {sel, dir, exp_step(c, steps), load && c >= t_load && c < t_load + P,
                    c <= t_done, c == t_done, c == t_done + 1, 1'b0};
            got  = {PHASESEL, PHASEDIR, PHASESTEP, PHASELOADREG, BUSY, DONE, REQ_READY, ERR};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL wave c=%0d sel=%0d dir=%0d steps=%0d load=%0d: got %b want %b",
                         c, sel, dir, steps, load, got, want);
            end
            // lock dropping well before WAIT_LOCK must not disturb the sequence
            if (glitch && c == 2) PLL_LOCK = 1'b0;
            if (glitch && c == 4) PLL_LOCK = 1'b1;
            if (c <= t_done) tick();
        end
        model_move(sel, dir, steps);
        check_pos_all();
    endtask

    task automatic apply_reset();
        RST = 1'b1;
        REQ_VALID = 1'b0; REQ_SEL = 2'd0; REQ_DIR = 1'b0; REQ_STEPS = '0; REQ_LOAD = 1'b0;
        POS_RD_SEL = 2'd0;
        for (int i = 0; i < 4; i++) pos_m[i] = 0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        logic [7:0] want, got;
        PLL_LOCK = 1'b1;
        apply_reset();
        got  = {REQ_READY, PHASESEL, PHASEDIR, PHASESTEP, PHASELOADREG, BUSY, DONE};
        want = 8'b1000_0000;
        n_checks++;
        if (got !== want || ERR !== 1'b0) begin
            n_fail++;
            $display("FAIL reset outputs: got %b err=%b want %b err=0", got, ERR, want);
        end
        check_pos_all();
        RST = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_directed();
        run_req(2'd2, 1'b0, 3, 1'b0, 1'b0);
        run_req(2'd1, 1'b1, 0, 1'b1, 1'b0);
        run_req(2'd0, 1'b0, 0, 1'b0, 1'b0);
        run_req(2'd3, 1'b0, 2, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            int steps;
            steps = int'($urandom_range(0, 5));
            run_req(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), steps,
                    1'($urandom_range(0, 1)), steps > 0 && $urandom_range(0, 1) == 1);
        end
    endtask

    task automatic test_timeout();
        logic [8:0] got, want;
        PLL_LOCK = 1'b0;
        repeat (3) tick();
        wait_ready();
        REQ_SEL = 2'd1; REQ_DIR = 1'b1; REQ_STEPS = STEP_W'(1); REQ_LOAD = 1'b0;
        REQ_VALID = 1'b1;
        tick();
        REQ_VALID = 1'b0;
        // WAIT_LOCK occupies cycles 9..24, timeout DONE+ERR at 25
        for (int c = 1; c <= 26; c++) begin
            want = {2'd1, 1'b1, exp_step(c, 1), 1'b0, c <= 25, c == 25, c == 26, c >= 25};
            got  = {PHASESEL, PHASEDIR, PHASESTEP, PHASELOADREG, BUSY, DONE, REQ_READY, ERR};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL timeout c=%0d: got %b want %b", c, got, want);
            end
            if (c < 26) tick();
        end
        model_move(1, 1'b1, 1);
        PLL_LOCK = 1'b1;
        repeat (4) tick();
        n_checks++;
        if (ERR !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got %b want 1", ERR);
        end
        run_req(2'd2, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int ready_cnt, done_cnt, last_done;
        wait_ready();
        REQ_SEL = 2'd3; REQ_DIR = 1'b0; REQ_STEPS = STEP_W'(1); REQ_LOAD = 1'b0;
        REQ_VALID = 1'b1;
        ready_cnt = 0; done_cnt = 0; last_done = -1;
        // One sequence = 11 cycles: accept at 0, DONE at 10, READY again at 11
        for (int c = 0; c < 60; c++) begin
            if (REQ_READY === 1'b1) ready_cnt++;
            if (DONE === 1'b1) begin
                done_cnt++;
                if (last_done >= 0) begin
                    n_checks++;
                    if (c - last_done != 11) begin
                        n_fail++;
                        $display("FAIL b2b spacing: got %0d want 11", c - last_done);
                    end
                end
                last_done = c;
            end
            if (c == 59) REQ_VALID = 1'b0;
            else tick();
        end
        n_checks++;
        if (ready_cnt != 6 || done_cnt != 5) begin
            n_fail++;
            $display("FAIL b2b counts: got ready=%0d done=%0d want ready=6 done=5",
                     ready_cnt, done_cnt);
        end
        pos_m[3] = (pos_m[3] + ready_cnt) & ((1 << POS_W) - 1);
        wait_ready();
        check_pos_all();
    endtask

    task automatic test_reset_mid();
        wait_ready();
        REQ_SEL = 2'd0; REQ_DIR = 1'b0; REQ_STEPS = STEP_W'(3); REQ_LOAD = 1'b0;
        POS_RD_SEL = 2'd0;
        REQ_VALID = 1'b1;
        tick();
        REQ_VALID = 1'b0;
        repeat (8) tick();
        n_checks++;
        if (PHASESTEP !== 1'b1) begin
            n_fail++;
            $display("FAIL mid second pulse: PHASESTEP got %b want 1", PHASESTEP);
        end
        #2 RST = 1'b1;
        #1;
        n_checks++;
        if ({PHASESTEP, PHASELOADREG, BUSY, REQ_READY} !== 4'b0001 || POS !== '0) begin
            n_fail++;
            $display("FAIL async reset: got step=%b load=%b busy=%b ready=%b pos=%h want 0 0 0 1 0",
                     PHASESTEP, PHASELOADREG, BUSY, REQ_READY, POS);
        end
        for (int i = 0; i < 4; i++) pos_m[i] = 0;
        #2 RST = 1'b0;
        tick();
        n_checks++;
        if (REQ_READY !== 1'b1 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL after reset release: ready=%b busy=%b want 1 0", REQ_READY, BUSY);
        end
        repeat (3) tick();
    endtask

    task automatic test_pos_negative();
        run_req(2'd0, 1'b1, 5, 1'b0, 1'b0);
        n_checks++;
        POS_RD_SEL = 2'd0;
        #1;
        if (POS !== (POS_EN ? 10'h3FB : 10'h000)) begin
            n_fail++;
            $display("FAIL pos_negative: got %h want %h", POS, POS_EN ? 10'h3FB : 10'h000);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_pos_negative();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
